par_to_ser: RTL
===============

Name: par_to_ser

Overview:
Parallel-to-serial converter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with valid and frame markers. Sits directly upstream of the bit-serial consumers in the flip-flop/latch library, such as the multiple-of-3 detector (mul_3), and drives their serial `in` input.
Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8: data word width; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0: value driven on ser_out whenever ser_valid=0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  upstream has a word on load_data.
- load_ready  out  1  block can accept a word this cycle (combinational from state).
- load_data  in  WIDTH  parallel word; sampled only on accept.
- ser_out  out  1  serial data bit (registered).
- ser_valid  out  1  ser_out carries a frame bit (registered).
- frame_start  out  1  high on the first bit of a frame (registered).
- frame_end  out  1  high on the last bit of a frame (registered).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SHIFT; plus PARITY when the optional feature is compiled in.
- Internal registers: shift register sreg[WIDTH-1:0]; bit counter cnt of width clog2(WIDTH); cnt counts 0..WIDTH-1.
- Reset (async, takes effect immediately): state=IDLE, cnt=0, sreg=0, ser_out=IDLE_LEVEL, ser_valid=0, frame_start=0, frame_end=0, busy=0. load_ready=1 once reset is released.
- Accept condition: load_valid & load_ready. load_data is ignored in every other cycle.
- load_ready=1 in IDLE, and in SHIFT when cnt==WIDTH-1 (last data bit). Without parity this allows back-to-back accepts. load_ready=0 in all other cycles.
- Accept in IDLE:
  - Next edge: state=SHIFT, cnt=0, ser_valid=1, frame_start=1.
  - ser_out = load_data[WIDTH-1] if MSB_FIRST, else load_data[0].
  - sreg = load_data, shifted so the next bit is positioned for the following cycle.
  - Latency from accept edge to first serial bit is 1 cycle.
- SHIFT, per edge:
  - cnt increments; ser_out = next bit; frame_start=0.
  - frame_end=1 on the edge that presents bit index WIDTH-1, i.e. cnt becomes WIDTH-1.
- End of frame (edge after the last bit, cnt==WIDTH-1):
  - If accept in that cycle: reload as in IDLE. The first bit of the new word follows the last bit of the old word with no gap; frame_start=1, frame_end=0.
  - Else: state=IDLE, ser_valid=0, ser_out=IDLE_LEVEL, frame_start=0, frame_end=0.
- A frame always occupies exactly WIDTH consecutive ser_valid cycles. It cannot be stalled; there is no downstream ready.
- If WIDTH==1 were allowed, frame_start and frame_end would both be high. WIDTH<2 is illegal.
- Reset asserted mid-frame: the frame is aborted and the remaining bits are lost. No partial-frame marker is emitted. The first load after reset starts a clean frame.
- load_valid may drop at any time without an accept; the block holds no record of it.

Optional Feature:
- Macro: PAR_TO_SER_PARITY_EN.
- When defined:
  - After the last data bit the FSM enters PARITY for one cycle.
  - ser_out = even parity (XOR) of the accepted word, with ser_valid=1.
  - frame_end moves from the last data bit to the parity bit.
  - load_ready is high in IDLE and in PARITY; it is low on the last data bit.
  - An accept during PARITY reloads with no gap.
  - Frame length is WIDTH+1 cycles.
- When not defined:
  - PARITY state and parity logic are absent.
  - Behaviour is exactly as described above.

Test Plan:
1. Single word, MSB first. WIDTH=8, MSB_FIRST=1, load 8'hA5 while idle.
   - Response: cycles 1..8 after accept show ser_out=1,0,1,0,0,1,0,1.
   - ser_valid=1 for exactly those 8 cycles; frame_start on cycle 1; frame_end on cycle 8.
   - Cycle 9: ser_valid=0, ser_out=0, busy=0.
2. Back-to-back. Hold load_valid=1 with 8'h0F, then 8'hF0 at the second accept.
   - Response: 16 continuous ser_valid cycles with bits 00001111 11110000.
   - frame_start on bits 1 and 9; frame_end on bits 8 and 16.
   - load_ready is high only on idle and on bit 8.
3. Load during shift. Assert load_valid=1 with 8'h33 at bit 3 of a 8'hFF frame.
   - Response: load_ready=0 until bit 8, accept occurs there, and 8'h33 follows with no gap.
   - load_data values before the accept do not appear on ser_out.
4. LSB first. MSB_FIRST=0, load 8'h01.
   - Response: first bit 1, then seven 0s; frame_end on the 8th bit.
5. Reset mid-frame. Assert rst asynchronously (between edges) at bit 4 of 8'hA5.
   - Response: ser_valid, frame_start, frame_end and busy go to 0 and ser_out to IDLE_LEVEL without waiting for a clock edge.
   - After release, load 8'h3C: clean frame 00111100 with frame_start on bit 1.
6. Parity (PAR_TO_SER_PARITY_EN defined).
   - 8'hA5: 9th bit = 0, frame_end on bit 9.
   - 8'h07: 9th bit = 1.
   - Back-to-back 8'hA5 then 8'h07: continuous 18 valid cycles, load_ready high on the parity bit only.

Source files
------------

// File: rtl/par_to_ser.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock with frame markers. Optional parity bit: PAR_TO_SER_PARITY_EN.
module par_to_ser #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a word transfers on a rising edge where load_valid && load_ready;
  // load_ready depends only on state, load_data is sampled only on that edge.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef PAR_TO_SER_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`else
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);
`endif

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_frame_start;
  logic             r_frame_end;
`ifdef PAR_TO_SER_PARITY_EN
  logic             r_parity;
`endif

  logic             w_last_bit;
  logic             w_accept;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_sreg_rest;

  assign w_last_bit  = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
  assign w_accept    = load_valid & load_ready;

  // The first bit goes straight to ser_out; sreg keeps the rest pre-shifted.
  assign w_load_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign w_load_rest = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
  assign w_next_bit  = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
  assign w_sreg_rest = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);

  always_comb begin
    load_ready = 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
    load_ready = (r_state == S_IDLE) || (r_state == S_PARITY);
`else
    load_ready = (r_state == S_IDLE) || w_last_bit;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sreg        <= '0;
      r_ser_out     <= IDLE_LEVEL;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state       <= S_SHIFT;
      r_cnt         <= '0;
      r_sreg        <= w_load_rest;
      r_ser_out     <= w_load_bit;
      r_ser_valid   <= 1'b1;
      r_frame_start <= 1'b1;
      r_frame_end   <= 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
      r_parity      <= ^load_data;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (!w_last_bit) begin
            r_cnt         <= r_cnt + CW'(1);
            r_sreg        <= w_sreg_rest;
            r_ser_out     <= w_next_bit;
            r_frame_start <= 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
            r_frame_end   <= 1'b0;
`else
            r_frame_end   <= (r_cnt == CNT_PENULT);
`endif
          end else begin
`ifdef PAR_TO_SER_PARITY_EN
            // Parity bit closes the frame and carries the end marker.
            r_state       <= S_PARITY;
            r_ser_out     <= r_parity;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b1;
`else
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ser_out     <= IDLE_LEVEL;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_cnt         <= '0;
          r_ser_out     <= IDLE_LEVEL;
          r_ser_valid   <= 1'b0;
          r_frame_start <= 1'b0;
          r_frame_end   <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out     = r_ser_out;
  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
